// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite definitions: transfer/size/response encodings, the SRAM slave
// state type and the byte-enable generator.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Widest supported bus is 1024 bits, i.e. 128 byte lanes.
    localparam int BE_MAX = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Lanes [offset, offset + 2**size) are set; callers keep the low bus-width bits.
    function automatic logic [BE_MAX-1:0] gen_be(input logic [2:0] size,
                                                 input logic [6:0] offset);
        logic [BE_MAX-1:0] mask;
        int                nbytes;
        nbytes = 1 << size;
        mask   = '0;
        for (int i = 0; i < BE_MAX; i++) begin
            if (i >= int'(offset) && i < int'(offset) + nbytes) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/peripheral_ahb3_sram_array.sv
// Two-port byte-enabled RAM with a registered read port; replace with a
// technology macro without touching the bus logic.
module peripheral_ahb3_sram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage has no reset so it maps onto plain RAM; only the read register is cleared.
    always_ff @(posedge hclk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // A read colliding with a write returns the old word; the slave forwards around it.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/peripheral_ahb3_sram_ws.sv
// AHB3-Lite SRAM slave with configurable wait states and a one-entry forwarding
// write buffer. Define PERIPHERAL_AHB3_SRAM_ERROR_EN for ERROR responses on illegal transfers.
module peripheral_ahb3_sram_ws
    import peripheral_ahb3_pkg::*;
#(
    parameter int HADDR_SIZE   = 32,
    parameter int HDATA_SIZE   = 32,
    parameter int MEMORY_DEPTH = 256,
    parameter int WAIT_STATES  = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [HADDR_SIZE-1:0] haddr,
    input  logic [HDATA_SIZE-1:0] hwdata,
    output logic [HDATA_SIZE-1:0] hrdata,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [1:0]            htrans,
    input  logic                  hmastlock,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int BE_W  = HDATA_SIZE / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    state_t              state, state_nxt;
    logic [3:0]          wait_cnt, wait_cnt_nxt;
    logic [IDX_W-1:0]    idx_in, addr_q;
    logic [BE_MAX-1:0]   be_full;
    logic [BE_W-1:0]     be_in, be_q;
    logic                wr_q;
    logic                accept, accept_rd, illegal, capture;

    logic                buf_valid;
    logic [IDX_W-1:0]    buf_addr;
    logic [BE_W-1:0]     buf_be;
    logic [HDATA_SIZE-1:0] buf_data;

    logic [BE_W-1:0]       fwd_be, fwd_be_nxt;
    logic [HDATA_SIZE-1:0] fwd_data, fwd_data_nxt, arr_rdata;

    assign idx_in  = haddr[OFF_W +: IDX_W];
    assign be_full = gen_be(hsize, 7'(haddr & HADDR_SIZE'(BE_W - 1)));
    assign be_in   = be_full[BE_W-1:0];

`ifdef PERIPHERAL_AHB3_SRAM_ERROR_EN
    logic [7:0] size_bytes;
    assign size_bytes = 8'd1 << hsize;
    assign illegal = ((haddr >> (OFF_W + IDX_W)) != '0)
                  || (int'(hsize) > OFF_W)
                  || ((7'(haddr) & 7'(size_bytes - 8'd1)) != 7'd0);
`else
    assign illegal = 1'b0;
`endif

    // New address phases are only taken while the slave is not stalling the bus.
    assign accept = hsel && hready
                 && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                 && (state == ST_IDLE || state == ST_DATA);
    assign accept_rd = accept && !illegal && !hwrite;
    assign capture   = (state == ST_DATA) && wr_q;

    // NOTE: every always_comb assigns its outputs a default first, so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            ST_IDLE, ST_DATA: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = 4'(WAIT_STATES);
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt    = ST_DATA;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign hreadyout = !(state == ST_WAIT || state == ST_ERR1);
    assign hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                addr_q <= idx_in;
                be_q   <= be_in;
                wr_q   <= hwrite;
            end
        end
    end

    // The buffer lives exactly one cycle: filled at the end of DATA, drained next edge.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_be    <= '0;
            buf_data  <= '0;
        end else begin
            buf_valid <= capture;
            if (capture) begin
                buf_addr <= addr_q;
                buf_be   <= be_q;
                buf_data <= hwdata;
            end
        end
    end

    // Newest data wins: the write being captured now, then the buffer, then the array.
    always_comb begin
        fwd_be_nxt   = '0;
        fwd_data_nxt = '0;
        for (int b = 0; b < BE_W; b++) begin
            if (buf_valid && buf_addr == idx_in && buf_be[b]) begin
                fwd_be_nxt[b]          = 1'b1;
                fwd_data_nxt[8*b +: 8] = buf_data[8*b +: 8];
            end
            if (capture && addr_q == idx_in && be_q[b]) begin
                fwd_be_nxt[b]          = 1'b1;
                fwd_data_nxt[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            fwd_be   <= '0;
            fwd_data <= '0;
        end else if (accept_rd) begin
            fwd_be   <= fwd_be_nxt;
            fwd_data <= fwd_data_nxt;
        end
    end

    always_comb begin
        hrdata = arr_rdata;
        for (int b = 0; b < BE_W; b++) begin
            if (fwd_be[b]) begin
                hrdata[8*b +: 8] = fwd_data[8*b +: 8];
            end
        end
    end

    peripheral_ahb3_sram_array #(
        .DATA_W (HDATA_SIZE),
        .DEPTH  (MEMORY_DEPTH),
        .ADDR_W (IDX_W)
    ) u_array (
        .hclk    (hclk),
        .hresetn (hresetn),
        .we      (buf_valid),
        .waddr   (buf_addr),
        .wbe     (buf_be),
        .wdata   (buf_data),
        .re      (accept_rd),
        .raddr   (idx_in),
        .rdata   (arr_rdata)
    );

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hmastlock, haddr, be_full};

endmodule
